// File: rtl/te_commit_grouper.sv
// Trace commit grouper: folds up to NRET in-order commits per cycle into trace packets
// behind a registered valid/ready output, with per-port acknowledge and count-saturation close.
module te_commit_grouper #(
  parameter int NRET        = 2,
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 10,
  parameter int ITYPE_LEN   = 3,
  parameter int PRIV_LEN    = 2,
  parameter int MAX_ICNT    = 1020
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NRET-1:0]                     valid_i,
  input  logic [NRET-1:0][XLEN-1:0]           pc_i,
  input  logic [NRET-1:0][ITYPE_LEN-1:0]      itype_i,
  input  logic [NRET-1:0]                     compressed_i,
  input  logic [NRET-1:0][PRIV_LEN-1:0]       priv_i,
  input  logic [XLEN-1:0]                     cause_i,
  input  logic [XLEN-1:0]                     tval_i,
  output logic [NRET-1:0]                     commit_ack_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [IRETIRE_LEN-1:0]              iretire_o,
  output logic                                ilastsize_o,
  output logic [ITYPE_LEN-1:0]                itype_o,
  output logic [XLEN-1:0]                     cause_o,
  output logic [XLEN-1:0]                     tval_o,
  output logic [PRIV_LEN-1:0]                 priv_o,
  output logic [XLEN-1:0]                     iaddr_o
);

  localparam logic [IRETIRE_LEN-1:0] MaxCnt = IRETIRE_LEN'(MAX_ICNT);
  localparam logic [ITYPE_LEN-1:0]   ItExc  = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0]   ItIrq  = ITYPE_LEN'(2);

  logic                   open_q, open_d;
  logic [IRETIRE_LEN-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]        iaddr_q, iaddr_d;
  logic                   last_q, last_d;

  logic                   valid_q;
  logic [IRETIRE_LEN-1:0] iret_q, iret_d;
  logic                   ls_q, ls_d;
  logic [ITYPE_LEN-1:0]   ity_q, ity_d;
  logic [XLEN-1:0]        cause_q, cause_d, tval_q, tval_d, piaddr_q, piaddr_d;
  logic [PRIV_LEN-1:0]    priv_q, priv_d;

  logic                   pkt_v, free, stop, live, sat, is_trap;
  logic [IRETIRE_LEN-1:0] t_cnt;
  logic [XLEN-1:0]        t_iaddr;
  logic                   t_last, t_open;

  // Walk ports oldest first; group state carries across ports within the cycle.
  always_comb begin
    commit_ack_o = '0;
    open_d   = open_q;
    cnt_d    = cnt_q;
    iaddr_d  = iaddr_q;
    last_d   = last_q;
    pkt_v    = 1'b0;
    iret_d   = '0;
    ls_d     = 1'b0;
    ity_d    = '0;
    cause_d  = '0;
    tval_d   = '0;
    priv_d   = '0;
    piaddr_d = '0;
    free     = !valid_q || ready_i;
    stop     = 1'b0;
    live     = 1'b0;
    sat      = 1'b0;
    is_trap  = 1'b0;
    t_cnt    = '0;
    t_iaddr  = '0;
    t_last   = 1'b0;
    t_open   = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      is_trap = (itype_i[k] == ItExc) || (itype_i[k] == ItIrq);
      live    = valid_i[k] || ((k == 0) && (valid_i == '0) && is_trap);
      if (!stop && live) begin
        if (valid_i[k]) begin
          t_cnt   = (open_d ? cnt_d : '0) + (compressed_i[k] ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2));
          t_iaddr = open_d ? iaddr_d : pc_i[k];
          t_last  = !compressed_i[k];
          t_open  = 1'b1;
        end else begin
          t_cnt   = cnt_d;
          t_iaddr = iaddr_d;
          t_last  = last_d;
          t_open  = open_d;
        end
        sat = valid_i[k] && (t_cnt >= MaxCnt);
        if (itype_i[k] == '0 && !sat) begin
          commit_ack_o[k] = 1'b1;
          open_d  = t_open;
          cnt_d   = t_cnt;
          iaddr_d = t_iaddr;
          last_d  = t_last;
        end else begin
          stop = 1'b1;
          if (free) begin
            commit_ack_o[k] = 1'b1;
            pkt_v    = 1'b1;
            iret_d   = t_cnt;
            ls_d     = t_last;
            ity_d    = itype_i[k];
            priv_d   = priv_i[k];
            piaddr_d = t_iaddr;
            cause_d  = is_trap ? cause_i : '0;
            tval_d   = (itype_i[k] == ItExc) ? tval_i : '0;
            open_d   = 1'b0;
            cnt_d    = '0;
            iaddr_d  = t_iaddr;
            last_d   = t_last;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      open_q   <= 1'b0;
      cnt_q    <= '0;
      iaddr_q  <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      iret_q   <= '0;
      ls_q     <= 1'b0;
      ity_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      priv_q   <= '0;
      piaddr_q <= '0;
    end else begin
      open_q  <= open_d;
      cnt_q   <= cnt_d;
      iaddr_q <= iaddr_d;
      last_q  <= last_d;
      if (pkt_v) begin
        valid_q  <= 1'b1;
        iret_q   <= iret_d;
        ls_q     <= ls_d;
        ity_q    <= ity_d;
        cause_q  <= cause_d;
        tval_q   <= tval_d;
        priv_q   <= priv_d;
        piaddr_q <= piaddr_d;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o     = valid_q;
  assign iretire_o   = iret_q;
  assign ilastsize_o = ls_q;
  assign itype_o     = ity_q;
  assign cause_o     = cause_q;
  assign tval_o      = tval_q;
  assign priv_o      = priv_q;
  assign iaddr_o     = piaddr_q;

endmodule

// File: tb/tb_te_commit_grouper.sv
// Bench for te_commit_grouper: directed scenarios with literal expectations, then random
// commit traffic checked every cycle against a packet-level model.
module tb_te_commit_grouper;
  localparam int NRET = 2, XLEN = 32, IL = 10, TL = 3, PL = 2, MAXI = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NRET-1:0]          valid = '0, comp = '0, ack;
  logic [NRET-1:0][XLEN-1:0] pc = '0;
  logic [NRET-1:0][TL-1:0]  itype = '0;
  logic [NRET-1:0][PL-1:0]  priv = '0;
  logic [XLEN-1:0]          cause = '0, tval = '0;
  logic                     ready = 1'b1;
  logic                     valid_o, ilastsize_o;
  logic [IL-1:0]            iretire_o;
  logic [TL-1:0]            itype_o;
  logic [XLEN-1:0]          cause_o, tval_o, iaddr_o;
  logic [PL-1:0]            priv_o;

  te_commit_grouper #(.NRET(NRET), .XLEN(XLEN), .IRETIRE_LEN(IL), .ITYPE_LEN(TL),
                      .PRIV_LEN(PL), .MAX_ICNT(MAXI)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .pc_i(pc), .itype_i(itype),
    .compressed_i(comp), .priv_i(priv), .cause_i(cause), .tval_i(tval),
    .commit_ack_o(ack), .valid_o(valid_o), .ready_i(ready), .iretire_o(iretire_o),
    .ilastsize_o(ilastsize_o), .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o),
    .priv_o(priv_o), .iaddr_o(iaddr_o));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [NRET-1:0] last_ack;

  // model: open group and the output register, as plain integers
  bit m_open; int m_cnt; logic [XLEN-1:0] m_ia; bit m_ls;
  bit o_v; int o_iret; bit o_ls; int o_ity; int o_priv; logic [XLEN-1:0] o_cause, o_tval, o_ia;
  bit n_open; int n_cnt; logic [XLEN-1:0] n_ia; bit n_ls;
  bit n_pkt; int p_iret; bit p_ls; int p_ity; int p_priv; logic [XLEN-1:0] p_cause, p_tval, p_ia;
  logic [NRET-1:0] exp_ack;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_cnt = 0; m_ia = '0; m_ls = 0;
    o_v = 0; o_iret = 0; o_ls = 0; o_ity = 0; o_priv = 0; o_cause = '0; o_tval = '0; o_ia = '0;
  endtask

  task automatic model_comb();
    bit free, op, ls, ls2, trap0;
    int c, c2, it;
    logic [XLEN-1:0] ia, ia2;
    free = !o_v || ready;
    exp_ack = '0; n_pkt = 0;
    c = m_cnt; op = m_open; ia = m_ia; ls = m_ls;
    for (int k = 0; k < NRET; k++) begin
      it = int'(itype[k]);
      trap0 = (k == 0) && (valid == '0) && (it == 1 || it == 2);
      if (!valid[k] && !trap0) continue;
      if (valid[k]) begin
        c2 = (op ? c : 0) + (comp[k] ? 1 : 2);
        ia2 = op ? ia : pc[k];
        ls2 = !comp[k];
      end else begin
        c2 = c; ia2 = ia; ls2 = ls;
      end
      if (it == 0 && c2 < MAXI) begin
        exp_ack[k] = 1'b1; c = c2; op = 1; ia = ia2; ls = ls2;
        continue;
      end
      if (free) begin
        exp_ack[k] = 1'b1; n_pkt = 1;
        p_ia = ia2; p_iret = c2; p_ls = ls2; p_ity = it; p_priv = int'(priv[k]);
        p_cause = (it == 1 || it == 2) ? cause : '0;
        p_tval  = (it == 1) ? tval : '0;
        c = 0; op = 0; ia = ia2; ls = ls2;
      end
      break;
    end
    n_cnt = c; n_open = op; n_ia = ia; n_ls = ls;
  endtask

  task automatic model_seq();
    m_open = n_open; m_cnt = n_cnt; m_ia = n_ia; m_ls = n_ls;
    if (n_pkt) begin
      o_v = 1; o_iret = p_iret; o_ls = p_ls; o_ity = p_ity; o_priv = p_priv;
      o_cause = p_cause; o_tval = p_tval; o_ia = p_ia;
    end else if (ready) o_v = 0;
  endtask

  task automatic check_out();
    chk("valid_o", valid_o, o_v);
    if (o_v) begin
      chk("iretire_o", iretire_o, o_iret);
      chk("ilastsize_o", ilastsize_o, o_ls);
      chk("itype_o", itype_o, o_ity);
      chk("priv_o", priv_o, o_priv);
      chk("cause_o", cause_o, o_cause);
      chk("tval_o", tval_o, o_tval);
      chk("iaddr_o", iaddr_o, o_ia);
    end
  endtask

  // called just after a falling edge with inputs applied; returns just after the next falling edge
  task automatic run_cycle();
    #1;
    model_comb();
    last_ack = ack;
    chk("commit_ack_o", ack, exp_ack);
    @(posedge clk); #1;
    model_seq();
    check_out();
    @(negedge clk);
  endtask

  task automatic set(input logic [1:0] v, input logic [31:0] pc0, input int it0, input bit c0,
                     input logic [31:0] pc1, input int it1, input bit c1, input bit rdy);
    valid = v; pc[0] = pc0; pc[1] = pc1; itype[0] = TL'(it0); itype[1] = TL'(it1);
    comp[0] = c0; comp[1] = c1; ready = rdy; priv[0] = 2'd3; priv[1] = 2'd1;
  endtask

  task automatic pkt_chk(input string nm, input logic [31:0] ia, input int ir, input bit ls, input int it);
    chk({nm, "_valid"}, valid_o, 1'b1);
    chk({nm, "_iaddr"}, iaddr_o, ia);
    chk({nm, "_iretire"}, iretire_o, ir);
    chk({nm, "_ilastsize"}, ilastsize_o, ls);
    chk({nm, "_itype"}, itype_o, it);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", valid_o, 0); chk("rst_iretire", iretire_o, 0); chk("rst_iaddr", iaddr_o, 0);
    chk("rst_itype", itype_o, 0); chk("rst_cause", cause_o, 0); chk("rst_priv", priv_o, 0);
    @(negedge clk); rst_n = 1'b1;

    set(2'b11, 32'h1000, 0, 0, 32'h1004, 4, 1, 1); run_cycle();
    chk("t1_ack", last_ack, 2'b11); pkt_chk("t1", 32'h1000, 3, 0, 4);

    set(2'b11, 32'h2000, 4, 0, 32'h3000, 0, 0, 1); run_cycle();
    chk("t2_ack", last_ack, 2'b01); pkt_chk("t2", 32'h2000, 2, 1, 4);
    set(2'b01, 32'h3000, 0, 0, 0, 0, 0, 1); run_cycle();
    chk("t2b_ack", last_ack, 2'b01); chk("t2b_valid", valid_o, 0);
    set(2'b01, 32'h3004, 4, 1, 0, 0, 0, 1); run_cycle();
    pkt_chk("t2c", 32'h3000, 3, 0, 4);

    for (int i = 0; i < 3; i++) begin
      set(2'b01, 32'h4000, 4, 0, 0, 0, 0, 0); run_cycle();
      chk("t3_hold_ack", last_ack, 2'b00); pkt_chk("t3_hold", 32'h3000, 3, 0, 4);
    end
    set(2'b01, 32'h4000, 4, 0, 0, 0, 0, 1); run_cycle();
    chk("t3_ack", last_ack, 2'b01); pkt_chk("t3", 32'h4000, 2, 1, 4);

    set(2'b11, 32'h5000, 0, 0, 32'h5004, 0, 0, 1); run_cycle();
    set(2'b01, 32'h5008, 0, 1, 0, 0, 0, 1); run_cycle();
    cause = 32'd2; tval = 32'hdead;
    set(2'b00, 32'h9998, 1, 0, 0, 0, 0, 1); run_cycle();
    chk("t4_ack", last_ack, 2'b01); pkt_chk("t4", 32'h5000, 5, 0, 1);
    chk("t4_cause", cause_o, 2); chk("t4_tval", tval_o, 32'hdead); chk("t4_priv", priv_o, 3);

    set(2'b11, 32'h6000, 0, 0, 32'h6004, 0, 0, 1); run_cycle();
    set(2'b11, 32'h6008, 0, 0, 32'h600c, 0, 0, 1); run_cycle();
    chk("t5_ack", last_ack, 2'b11); pkt_chk("t5", 32'h6000, 8, 1, 0);
    chk("t5_cause", cause_o, 0); chk("t5_tval", tval_o, 0);
    set(2'b01, 32'h6010, 4, 0, 0, 0, 0, 1); run_cycle();
    pkt_chk("t5b", 32'h6010, 2, 1, 4);

    set(2'b11, 32'h7000, 0, 0, 32'h7004, 0, 1, 1); run_cycle();
    set(2'b11, 32'h7006, 0, 0, 32'h700a, 0, 0, 1); run_cycle();
    set(2'b11, 32'h700e, 0, 0, 32'h7012, 0, 0, 1); run_cycle();
    chk("t5c_ack", last_ack, 2'b01); pkt_chk("t5c", 32'h7000, 9, 1, 0);

    set(2'b01, 32'h7100, 4, 0, 0, 0, 0, 1); run_cycle();
    set(2'b01, 32'h7200, 0, 0, 0, 0, 0, 0); run_cycle();
    chk("t6_open_ack", last_ack, 2'b01);
    set(2'b00, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; #1;
    model_reset();
    chk("t6_valid", valid_o, 0); chk("t6_iaddr", iaddr_o, 0); chk("t6_iretire", iretire_o, 0);
    chk("t6_itype", itype_o, 0); chk("t6_tval", tval_o, 0);
    @(negedge clk); rst_n = 1'b1;
    set(2'b01, 32'h8000, 0, 1, 0, 0, 0, 1); run_cycle();
    set(2'b01, 32'h8002, 4, 1, 0, 0, 0, 1); run_cycle();
    pkt_chk("t6b", 32'h8000, 2, 0, 4);

    for (int n = 0; n < 4000; n++) begin
      int nv;
      nv = $urandom_range(0, NRET);
      valid = NRET'((1 << nv) - 1);
      for (int k = 0; k < NRET; k++) begin
        itype[k] = ($urandom_range(0, 9) < 6) ? TL'(0) : TL'($urandom_range(1, 7));
        comp[k]  = 1'($urandom_range(0, 1));
        pc[k]    = $urandom() & ~32'h1;
        priv[k]  = PL'($urandom_range(0, 3));
      end
      cause = $urandom();
      tval  = $urandom();
      ready = ($urandom_range(0, 3) != 0);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
